// File: rtl/rename_pkg.sv
// Shared rename-stage constants, the physical tag type and the free-list seed pattern.
package rename_pkg;

   localparam int PHYS_REGS = 64;
   localparam int ARCH_REGS = 32;
   localparam int TAG_W     = $clog2(PHYS_REGS);
   localparam int CAP       = PHYS_REGS - ARCH_REGS;
   localparam int PTR_W     = $clog2(CAP);
   localparam int CNT_W     = TAG_W + 1;

   typedef logic [TAG_W-1:0] tag_t;

   // Tags below ARCH_REGS back the identity mapping, so the list starts with the rest.
   function automatic tag_t tag_at_reset(input int unsigned i);
      return tag_t'(ARCH_REGS + i);
   endfunction

endpackage

// File: rtl/circ_fifo_ptr.sv
// Wrapping head/tail/count bookkeeping for a circular queue; storage lives in the parent.
module circ_fifo_ptr #(
   parameter int DEPTH       = 32,
   parameter int PTR_W       = 5,
   parameter int CNT_W       = 7,
   parameter int RESET_COUNT = DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_req,
   input  logic             pop_req,
   output logic [PTR_W-1:0] head,
   output logic [PTR_W-1:0] tail,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             push_ok,
   output logic             pop_ok
);

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign pop_ok  = pop_req && !empty;
   // A same-cycle pop makes room, so a push into a full queue is still accepted.
   assign push_ok = push_req && (!full || pop_ok);

   always_ff @(posedge clk) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= CNT_W'(RESET_COUNT);
      end else begin
         if (pop_ok)
            head <= wrap_inc(head);
         if (push_ok)
            tail <= wrap_inc(tail);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/phys_free_list.sv
// Free list of physical register tags: hands new tags to rename, reclaims superseded tags at commit.
module phys_free_list
   import rename_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc_req,
   output logic             alloc_valid,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             release_valid,
   input  logic [TAG_W-1:0] release_tag,
   output logic [CNT_W-1:0] free_count,
   output logic             full,
   output logic             overflow_err
);

   tag_t             mem [CAP];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             empty;
   logic             push_req;
   logic             push_ok;
   logic             pop_ok;

   // Tag 0 backs x0 and is never remapped, so returning it is a no-op.
   assign push_req = release_valid && (release_tag != '0);

   circ_fifo_ptr #(
      .DEPTH       (CAP),
      .PTR_W       (PTR_W),
      .CNT_W       (CNT_W),
      .RESET_COUNT (CAP)
   ) u_ptr (
      .clk      (clk),
      .reset    (reset),
      .push_req (push_req),
      .pop_req  (alloc_req),
      .head     (head),
      .tail     (tail),
      .count    (free_count),
      .empty    (empty),
      .full     (full),
      .push_ok  (push_ok),
      .pop_ok   (pop_ok)
   );

   assign alloc_valid = !empty;
   assign alloc_tag   = mem[head];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < CAP; i++)
            mem[i] <= tag_at_reset(i);
      end else if (push_ok) begin
         mem[tail] <= release_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         overflow_err <= 1'b0;
      else if (push_req && !push_ok)
         overflow_err <= 1'b1;
   end

endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: a queue-based model predicts each cycle's outputs.
module tb_phys_free_list;
   import rename_pkg::*;

   logic             clk = 1'b0;
   logic             reset;
   logic             alloc_req;
   logic             alloc_valid;
   logic [TAG_W-1:0] alloc_tag;
   logic             release_valid;
   logic [TAG_W-1:0] release_tag;
   logic [CNT_W-1:0] free_count;
   logic             full;
   logic             overflow_err;

   phys_free_list dut (
      .clk           (clk),
      .reset         (reset),
      .alloc_req     (alloc_req),
      .alloc_valid   (alloc_valid),
      .alloc_tag     (alloc_tag),
      .release_valid (release_valid),
      .release_tag   (release_tag),
      .free_count    (free_count),
      .full          (full),
      .overflow_err  (overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit check;
      bit valid;
      int tag;
      int cnt;
      bit full;
      bit ovf;
   } exp_t;

   exp_t exp_q[$];
   int   model[$];
   bit   model_ovf;
   bit   model_known;
   int   total;
   int   bad;

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Monitor: each cycle the DUT presents its outputs, compared against the oldest expectation.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.check) begin
            chk("alloc_valid", int'(alloc_valid), int'(e.valid));
            if (e.valid)
               chk("alloc_tag", int'(alloc_tag), e.tag);
            chk("free_count", int'(free_count), e.cnt);
            chk("full", int'(full), int'(e.full));
            chk("overflow_err", int'(overflow_err), int'(e.ovf));
         end
      end
   end

   // One cycle: record what the DUT should show now, drive inputs, advance the model to the next edge.
   task automatic cycle(input bit areq, input bit rv, input int rtag, input bit rst_n);
      exp_t e;
      bit   pop;
      bit   push_req;
      @(posedge clk);
      #1;
      alloc_req     = areq;
      release_valid = rv;
      release_tag   = TAG_W'(rtag);
      reset         = rst_n;
      e.check = model_known;
      e.valid = (model.size() != 0);
      e.tag   = (model.size() != 0) ? model[0] : 0;
      e.cnt   = model.size();
      e.full  = (model.size() == CAP);
      e.ovf   = model_ovf;
      exp_q.push_back(e);
      if (!rst_n) begin
         model.delete();
         for (int i = 0; i < CAP; i++)
            model.push_back(ARCH_REGS + i);
         model_ovf   = 1'b0;
         model_known = 1'b1;
      end else begin
         pop      = areq && (model.size() != 0);
         push_req = rv && (rtag != 0);
         if (push_req && !(model.size() == CAP && !pop))
            model.push_back(rtag);
         else if (push_req)
            model_ovf = 1'b1;
         if (pop)
            void'(model.pop_front());
      end
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 0, 1'b1);
   endtask

   task automatic do_reset();
      cycle(1'b0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      model_ovf     = 1'b0;
      model_known   = 1'b0;
      reset         = 1'b0;
      alloc_req     = 1'b0;
      release_valid = 1'b0;
      release_tag   = '0;

      do_reset();
      idle();
      // Drain all 32 tags, plus one request on an empty list.
      for (int i = 0; i < CAP + 1; i++)
         cycle(1'b1, 1'b0, 0, 1'b1);
      idle();
      // Release into an empty list with a concurrent request: no bypass.
      cycle(1'b1, 1'b1, 40, 1'b1);
      idle();
      // Full list: lone release is dropped; then alloc+release together is accepted.
      do_reset();
      cycle(1'b0, 1'b1, 5, 1'b1);
      cycle(1'b1, 1'b1, 5, 1'b1);
      idle();
      idle();
      // Release of tag 0 at count 10.
      do_reset();
      for (int i = 0; i < CAP - 10; i++)
         cycle(1'b1, 1'b0, 0, 1'b1);
      cycle(1'b0, 1'b1, 0, 1'b1);
      idle();
      // Wrap-around through index 0.
      do_reset();
      for (int i = 0; i < CAP; i++)
         cycle(1'b1, 1'b0, 0, 1'b1);
      cycle(1'b0, 1'b1, 7, 1'b1);
      cycle(1'b0, 1'b1, 9, 1'b1);
      cycle(1'b0, 1'b1, 11, 1'b1);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b0, 0, 1'b1);
      // Reset mid-traffic overrides a concurrent alloc and release.
      cycle(1'b1, 1'b1, 13, 1'b1);
      cycle(1'b1, 1'b1, 15, 1'b0);
      idle();
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 1'b0, 0, 1'b1);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         bit a;
         bit r;
         bit rs;
         int t;
         a  = ($urandom_range(0, 99) < 50);
         r  = ($urandom_range(0, 99) < 52);
         t  = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 63));
         rs = ($urandom_range(0, 199) != 0);
         cycle(a, r, t, rs);
      end
      idle();

      @(negedge clk);
      #1;
      chk("queue_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Circular FIFO of free physical register tags. It produces the new tag that rename writes into the logical-to-physical mapping table (that table's write_data).
- It reclaims the superseded tag when the overwriting instruction commits.
- Sits between rename (consumer of tags) and commit (returner of tags).
- After reset it holds every tag not occupied by the identity mapping.

Parameters:
- PHYS_REGS, 64, total physical registers; power of two, greater than ARCH_REGS.
- ARCH_REGS, 32, logical registers; tags 0..ARCH_REGS-1 are mapped at reset.
- TAG_W, 6, tag width, log2(PHYS_REGS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge; 0 = reset.
- alloc_req  in  1  rename requests one free tag this cycle.
- alloc_valid  out  1  a free tag is available (list not empty).
- alloc_tag  out  TAG_W  tag at head; meaningful only when alloc_valid=1.
- release_valid  in  1  commit returns one tag this cycle.
- release_tag  in  TAG_W  tag being returned.
- free_count  out  TAG_W+1  number of tags currently in the list.
- full  out  1  free_count == PHYS_REGS-ARCH_REGS.
- overflow_err  out  1  sticky; a release was dropped because the list was full.

Behaviour:
- Storage: PHYS_REGS-ARCH_REGS entries (CAP).
  - head and tail pointers, each log2(CAP) bits, wrap modulo CAP.
  - Count register is TAG_W+1 bits.
- Reset (reset==0 at an edge):
  - Entry i = ARCH_REGS+i for i in 0..CAP-1.
  - head=0, tail=0, count=CAP.
  - overflow_err=0.
  - Outputs after reset: alloc_valid=1, alloc_tag=ARCH_REGS, free_count=CAP, full=1.
- Reset priority: reset overrides any concurrent alloc or release in the same cycle.
- Allocate:
  - alloc_valid = (count!=0); alloc_tag = mem[head]. Both are combinational from registered state, so there is zero-latency lookup.
  - Pop when alloc_req && alloc_valid: head+1 and count-1 at the edge.
  - alloc_req while empty: ignored, no state change. Rename must stall.
- Release:
  - Push when release_valid && release_tag!=0 && !(full && !pop): mem[tail]=release_tag, tail+1, count+1.
  - release_tag==0: ignored silently. Tag 0 backs x0, which is never remapped.
  - Release while full with no same-cycle pop: dropped, and overflow_err is set to 1. It stays 1 until reset.
- Simultaneous pop and push:
  - Both pointers advance and count is unchanged.
  - When full, the pop frees space, so the push is accepted.
  - When empty, there is no pop: no bypass of release_tag to alloc_tag. The push is accepted, count becomes 1, and the tag is allocatable next cycle.
- Wrap-around: pointers wrap from CAP-1 to 0 with no bubble.
- No duplicate-tag detection. Commit guarantees each tag is released once.
- Single port each side: at most one alloc and one release per cycle.

Decomposition:
- Shared package rename_pkg:
  - PHYS_REGS, ARCH_REGS, TAG_W constants.
  - Tag typedef (logic [TAG_W-1:0]).
  - Reset-content function tag_at_reset(i)=ARCH_REGS+i.
- One natural sub-module: circ_fifo_ptr, the wrapping pointer/count logic with push/pop/full/empty.
  - Reusable later for the ROB and issue queue.
  - phys_free_list adds the tag storage, reset seeding and error flag around it.

Test Plan:
- Reset (reset=0 one cycle, then 1) -> alloc_valid=1, alloc_tag=32, free_count=32, full=1, overflow_err=0.
- 32 back-to-back alloc_req=1 -> tags 32,33,...,63 in order, one per cycle. Then alloc_valid=0 and free_count=0; a 33rd request changes nothing.
- From empty, release_tag=40 with alloc_req=1 in the same cycle -> no alloc that cycle, free_count=1. Next cycle alloc_valid=1, alloc_tag=40.
- Full list:
  - release_tag=5 alone -> dropped, overflow_err=1, free_count stays 32.
  - Next cycle alloc+release(5) together -> tag 32 allocated, 5 stored at tail, count stays 32, overflow_err stays 1.
- release_tag=0 with release_valid=1 on a list at count 10 -> count stays 10, no error.
- Wrap:
  - Alloc 32 tags, then release 7,9,11, then alloc 3 -> tags 7,9,11 returned in order; pointers wrap through index 0.
  - Assert reset=0 mid-sequence -> contents return to 32..63 on the next cycle.
